// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// Prefix levels are spread across PIPE_STAGES registers; the last stage holds the results.
module prefix_adder_pipe #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned LVLS = $clog2(WIDTH);
    localparam int unsigned NS   = PIPE_STAGES;

    logic          adv;
    logic [NS-1:0] v;

    // Single global advance: the pipe moves unless a held output is refused.
    assign adv       = ~v[NS-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v[NS-1];

    // Operand pre-processing; c0 is folded into bit 0's generate.
    logic [WIDTH-1:0] bx, pre_g, pre_p;
    logic             c0;

    always_comb begin
        bx       = sub ? ~b : b;
        c0       = sub | cin;
        pre_p    = a ^ bx;
        pre_g    = a & bx;
        pre_g[0] = pre_g[0] | (pre_p[0] & c0);
    end

    // Per-stage inputs: stage 0 sees the pre-processed operands, later stages the previous register.
    logic [WIDTH-1:0] cur_g  [NS];
    logic [WIDTH-1:0] cur_pg [NS];
    logic [WIDTH-1:0] cur_p  [NS];
    logic             cur_c0 [NS];

    assign cur_g[0]  = pre_g;
    assign cur_pg[0] = pre_p;
    assign cur_p[0]  = pre_p;
    assign cur_c0[0] = c0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (adv) begin
            v[0] <= in_valid;
            for (int k = 1; k < int'(NS); k++) begin
                v[k] <= v[k-1];
            end
        end
    end

    for (genvar k = 0; k < int'(NS); k++) begin : g_stage
        localparam int unsigned LO = (32'(k) * LVLS) / NS;
        localparam int unsigned HI = ((32'(k) + 1) * LVLS) / NS;

        logic [WIDTH-1:0] tg, tp, og, op;

        // Kogge-Stone levels [LO, HI) evaluated in this stage.
        always_comb begin
            tg = cur_g[k];
            tp = cur_pg[k];
            og = tg;
            op = tp;
            for (int l = 0; l < int'(LVLS); l++) begin
                if (l >= int'(LO) && l < int'(HI)) begin
                    og = tg;
                    op = tp;
                    for (int i = (1 << l); i < int'(WIDTH); i++) begin
                        tg[i] = og[i] | (op[i] & og[i - (1 << l)]);
                        tp[i] = op[i] & op[i - (1 << l)];
                    end
                end
            end
        end

        if (k < int'(NS) - 1) begin : g_mid
            logic [WIDTH-1:0] r_g, r_pg, r_p;
            logic             r_c0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_g  <= '0;
                    r_pg <= '0;
                    r_p  <= '0;
                    r_c0 <= 1'b0;
                end else if (adv) begin
                    r_g  <= tg;
                    r_pg <= tp;
                    r_p  <= cur_p[k];
                    r_c0 <= cur_c0[k];
                end
            end

            assign cur_g[k+1]  = r_g;
            assign cur_pg[k+1] = r_pg;
            assign cur_p[k+1]  = r_p;
            assign cur_c0[k+1] = r_c0;
        end else begin : g_last
            logic [WIDTH-1:0] carry_vec, sum_c;

            // tg[i] is now the carry out of bit i.
            always_comb begin
                carry_vec = {tg[WIDTH-2:0], cur_c0[k]};
                sum_c     = cur_p[k] ^ carry_vec;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum  <= '0;
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                    zero <= 1'b0;
                end else if (adv) begin
                    sum  <= sum_c;
                    cout <= tg[WIDTH-1];
                    ovf  <= tg[WIDTH-1] ^ tg[WIDTH-2];
                    zero <= ~|sum_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe at WIDTH=32, PIPE_STAGES=2.
module tb_prefix_adder_pipe;

    localparam int unsigned W = 32;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, sub, cout, ovf, zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prefix_adder_pipe #(.WIDTH(W), .PIPE_STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {zero, ovf, cout, sum}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input logic ci);
        logic [31:0] yy;
        logic [32:0] full;
        logic        c, ov;
        yy   = s ? ~y : y;
        c    = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + 33'(c);
        ov   = (x[31] == yy[31]) && (full[31] != x[31]);
        return {full[31:0] == 32'd0, ov, full[32], full[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_beat(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                            input logic xs, input logic xc, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez);
        a = xa; b = xb; sub = xs; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < int'(S) - 1; k++) begin
            chk({tag, "_early"}, 64'(out_valid), 64'd0);
            step();
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"},   64'(sum),  64'(es));
        chk({tag, "_cout"},  64'(cout), 64'(ec));
        chk({tag, "_ovf"},   64'(ovf),  64'(eo));
        chk({tag, "_zero"},  64'(zero), 64'(ez));
        step();
        chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    task automatic stream(input string tag, input int nb, input int st0, input int stlen,
                          input logic chk_lat);
        logic [34:0] q_exp[$];
        int          q_cyc[$];
        logic [34:0] e;
        int          lc;
        int          i = 0, nout = 0, first_out = -1, last_out = -1;
        for (int c = 0; c < nb + int'(S) + stlen + 10; c++) begin
            out_ready = !(c >= st0 && c < st0 + stlen);
            if (i < nb) begin
                a        = 32'h9E37_79B9 * 32'(i + 1);
                b        = 32'h7F4A_7C15 ^ (32'(i) * 32'h0101_0101);
                sub      = i[0];
                cin      = i[1];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
                if (q_exp.size() > 0) chk({tag, "_stall_sum"}, 64'(sum), 64'(q_exp[0][31:0]));
            end
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk({tag, "_spurious"}, 64'(q_exp.size()), 64'd1);
                end else begin
                    e  = q_exp.pop_front();
                    lc = q_cyc.pop_front();
                    chk({tag, "_sum"},   64'(sum), 64'(e[31:0]));
                    chk({tag, "_flags"}, 64'({zero, ovf, cout}), 64'(e[34:32]));
                    if (chk_lat) chk({tag, "_latency"}, 64'(c - lc), 64'(S));
                    if (first_out < 0) first_out = c;
                    last_out = c;
                    nout++;
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(model(a, b, sub, cin));
                q_cyc.push_back(c);
                i++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 64'(nout), 64'(nb));
        chk({tag, "_leftover"}, 64'(q_exp.size()), 64'd0);
        if (chk_lat) chk({tag, "_consecutive"}, 64'(last_out - first_out), 64'(nb - 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_outputs",   64'({sum, cout, ovf, zero}), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        step();

        one_beat("add",     32'hD573_235A, 32'h39A4_BE05, 1'b0, 1'b0, 32'h0F17_E15F, 1'b1, 1'b0, 1'b0);
        one_beat("sub",     32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        one_beat("ovf",     32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        one_beat("wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        one_beat("sub_eq",  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        one_beat("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        stream("burst", 8, -1, 0, 1'b1);
        stream("stall", 8, 4, 3, 1'b0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        a = 32'h0000_0011; b = 32'h0000_0022; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        step();
        a = 32'h0000_0033;
        step();
        in_valid = 1'b0;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_outputs",   64'({sum, cout, ovf, zero}), 64'd0);
        chk("midrst_in_ready",  64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no_stale_beat", 64'(out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
